// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Purpose:
//   Time-multiplexed scan controller for a two-digit 7-segment display.
//   The controller alternates between digit 0 (msb) and digit 1 (lsb). Each
//   digit is lit for DIV_MAX+1 cycles. An optional blanking gap of BLANK_CYC
//   cycles can follow each digit to suppress ghosting. Both segment patterns
//   are snapshotted at the start of every frame, so a frame never shows a
//   mix of old and new data.
//
// Configuration macro:
//   SEG_SCAN_BLANK_EN - when defined, the GAP0/GAP1 blanking states are part
//                       of the scan order (SHOW0 -> GAP0 -> SHOW1 -> GAP1).
//                       When undefined, the order is SHOW0 -> SHOW1 and
//                       BLANK_CYC has no effect.
//
// Parameters:
//   DIV_W      width of the dwell counter
//   DIV_MAX    dwell terminal count (1 .. 2^DIV_W-1)
//   BLANK_CYC  blanking gap length in cycles (1 .. 2^DIV_W)
//
// Ports:
//   clk        in   1  clock, all state changes on the rising edge
//   rst_n      in   1  asynchronous active-low reset
//   en         in   1  scan enable (level); 0 returns to IDLE on the next edge
//   msb_7      in   7  segment pattern for digit 0
//   lsb_7      in   7  segment pattern for digit 1
//   dec        out  1  downstream mux select: 0 = msb, 1 = lsb
//   seg_7      out  7  registered segment pattern, active-high
//   an         out  2  digit enables, active-high (an[0] = digit 0)
//   frame_tick out  1  one-cycle pulse in the first cycle of each new frame
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int DIV_W     = 16,
  parameter int DIV_MAX   = 49999,
  parameter int BLANK_CYC = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [6:0] msb_7,
  input  logic [6:0] lsb_7,
  output logic       dec,
  output logic [6:0] seg_7,
  output logic [1:0] an,
  output logic       frame_tick
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHOW0 = 3'd1,
    GAP0  = 3'd2,
    SHOW1 = 3'd3,
    GAP1  = 3'd4
  } state_t;

  // Terminal values are cast once so the comparisons are width-matched.
  localparam logic [DIV_W-1:0] SHOW_LAST = DIV_W'(DIV_MAX);
  localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(BLANK_CYC - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_next;
  logic [6:0]       r_snap_msb;
  logic [6:0]       r_snap_lsb;
  logic [6:0]       w_snap_msb_next;
  logic [6:0]       w_snap_lsb_next;
  logic             r_dec;
  logic             w_dec_next;
  logic [6:0]       r_seg;
  logic [6:0]       w_seg_next;
  logic [1:0]       r_an;
  logic [1:0]       w_an_next;
  logic             r_tick;
  logic             w_tick_next;
  logic             w_show_done;
  logic             w_gap_done;

  assign w_show_done = (r_cnt == SHOW_LAST);
  assign w_gap_done  = (r_cnt == GAP_LAST);

  // ---------------------------------------------------------------------------
  // Next-state, counter and snapshot logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt + DIV_W'(1);
    w_snap_msb_next = r_snap_msb;
    w_snap_lsb_next = r_snap_lsb;
    w_tick_next     = 1'b0;

    if (!en) begin
      // Disable wins over any terminal count reached in the same cycle.
      w_state_next = IDLE;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          // First frame after IDLE deliberately produces no frame_tick.
          w_state_next    = SHOW0;
          w_cnt_next      = '0;
          w_snap_msb_next = msb_7;
          w_snap_lsb_next = lsb_7;
        end
        SHOW0: begin
          if (w_show_done) begin
`ifdef SEG_SCAN_BLANK_EN
            w_state_next = GAP0;
`else
            w_state_next = SHOW1;
`endif
            w_cnt_next = '0;
          end
        end
        SHOW1: begin
          if (w_show_done) begin
`ifdef SEG_SCAN_BLANK_EN
            w_state_next = GAP1;
`else
            w_state_next    = SHOW0;
            w_snap_msb_next = msb_7;
            w_snap_lsb_next = lsb_7;
            w_tick_next     = 1'b1;
`endif
            w_cnt_next = '0;
          end
        end
        // Without blanking the GAP states are never entered from a legal
        // state; the shared handling below only matters with blanking on.
        GAP0: begin
          if (w_gap_done) begin
            w_state_next = SHOW1;
            w_cnt_next   = '0;
          end
        end
        GAP1: begin
          if (w_gap_done) begin
            w_state_next    = SHOW0;
            w_cnt_next      = '0;
            w_snap_msb_next = msb_7;
            w_snap_lsb_next = lsb_7;
            w_tick_next     = 1'b1;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode from the *next* state, so the registered outputs change on
  // the same edge as the state register and always describe the current state.
  // Segment data comes from the next snapshot value so the first SHOW0 cycle
  // of a frame already shows the freshly captured pattern.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_an_next  = 2'b00;
    w_seg_next = 7'h00;
    w_dec_next = r_dec;

    case (w_state_next)
      IDLE: begin
        w_dec_next = 1'b0;
      end
      SHOW0: begin
        w_an_next  = 2'b01;
        w_seg_next = w_snap_msb_next;
        w_dec_next = 1'b0;
      end
      SHOW1: begin
        w_an_next  = 2'b10;
        w_seg_next = w_snap_lsb_next;
        w_dec_next = 1'b1;
      end
      GAP0, GAP1: begin
        // Blank display, mux select left where it was.
        w_an_next  = 2'b00;
        w_seg_next = 7'h00;
      end
      default: begin
        w_dec_next = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_snap_msb <= 7'h00;
      r_snap_lsb <= 7'h00;
      r_dec      <= 1'b0;
      r_seg      <= 7'h00;
      r_an       <= 2'b00;
      r_tick     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_snap_msb <= w_snap_msb_next;
      r_snap_lsb <= w_snap_lsb_next;
      r_dec      <= w_dec_next;
      r_seg      <= w_seg_next;
      r_an       <= w_an_next;
      r_tick     <= w_tick_next;
    end
  end

  assign dec        = r_dec;
  assign seg_7      = r_seg;
  assign an         = r_an;
  assign frame_tick = r_tick;

endmodule
